act_unit_arbiter: RTL and testbench
===================================

Name: act_unit_arbiter

Overview:
- Shares one floating-point activation unit (start/x → y/done, vector of N lanes × S bits) among R requesters.
- Requesters are, for example, neuron or layer engines.
- Performs round-robin arbitration, latches the winner's operand vector, sequences the unit's start/done handshake and routes the result back with a one-cycle valid pulse.
- Adds a watchdog so a hung unit cannot deadlock the requesters.

Parameters:
- S, 32, float width per lane (IEEE-754 single).
- N, 2, lanes per vector.
- R, 4, number of requesters (2..8).
- TIMEOUT, 1000, max WAIT cycles before error (≥1).
- CW, 16, watchdog counter width (2^CW > TIMEOUT).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  R  per-requester request level; held until its rsp_valid.
- req_x  in  R*S*N  requester r operand vector at bits [(r+1)*S*N-1 : r*S*N].
- gnt  out  R  one-hot; bit r high from grant cycle through RESP cycle.
- rsp_valid  out  R  one-cycle pulse to the served requester.
- rsp_y  out  S*N  result register, valid when any rsp_valid is high; held otherwise.
- rsp_err  out  1  high with rsp_valid when the operation timed out.
- unit_start  out  1  start pulse to the activation unit.
- unit_x  out  S*N  latched operand to the unit; stable from START until leaving RESP.
- unit_y  in  S*N  unit result.
- unit_done  in  1  unit done level; stays high after completion until next start.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, rsp_valid=0, rsp_y=0, rsp_err=0, unit_start=0, unit_x=0, busy=0; rr pointer=0; watchdog=0.
- FSM states: IDLE, START, GUARD, WAIT, RESP.
- IDLE:
  - If req≠0, select the first set bit searching from index ptr upward with wrap mod R.
  - Latch that requester's req_x into unit_x, set gnt one-hot, go to START.
  - Otherwise stay in IDLE.
- START: unit_start=1 for exactly this cycle; go to GUARD.
- GUARD:
  - unit_done is ignored, because it may still be high from the previous operation until the unit sees start.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - If unit_done=1: capture unit_y into rsp_y, rsp_err←0, go to RESP.
  - Else if watchdog==TIMEOUT-1: rsp_y←0, rsp_err←1, go to RESP.
  - Else watchdog+1.
  - If done and timeout coincide, done wins (err=0).
- RESP:
  - rsp_valid[g]=1 for this cycle only; gnt still = g.
  - ptr←(g+1) mod R; next state IDLE, gnt cleared.
- Latency:
  - Grant at cycle t (IDLE); unit_start at t+1; unit_done can first be accepted at t+3.
  - Done seen at cycle d gives rsp_valid at d+1.
  - Next grant at the earliest d+2, so there is one idle cycle between operations.
- Requester rule: deassert req in the cycle after rsp_valid.
  - req is only sampled in IDLE, so a same-edge deassert is never re-granted.
- req dropped mid-operation: the operation completes and rsp_valid is still pulsed; there is no abort.
- req_x changes after grant are ignored because unit_x is latched.
- Fairness: a requester holding req waits at most R-1 operations.
- rst_n asserted mid-operation:
  - Immediate return to reset values; any pending response is lost and no rsp_valid is issued.
  - The unit is not explicitly reset by this block.
  - The next operation's start pulse reinitialises the unit.
- rsp_err is sticky only until the next RESP; it is updated only in WAIT→RESP.

Test Plan:
- Single request: req=0001, req_x={0x3f800000,0x00000000}, unit model latency 12 → unit_start one cycle after grant; rsp_valid=0001 exactly once; rsp_y={0x3f400000,0x3f000000}; rsp_err=0.
- Simultaneous requests: req=1010 with ptr=0 → served order r1 then r3 then, if still held, r1; gnt one-hot; one idle cycle between operations; r3 operand {0xbf800000,0xbf800000} → rsp_y={0x3e800000,0x3e800000}.
- All four requesting continuously for 8 operations → grant sequence 0,1,2,3,0,1,2,3; no requester starved.
- Stale done: model keeps unit_done=1 from the previous op until it sees start → arbiter does not accept it in GUARD; rsp_y equals the new result, not the old one.
- Timeout: model never raises done, TIMEOUT=20 → rsp_valid exactly 20 WAIT cycles after entering WAIT, rsp_err=1, rsp_y=0; next requester served normally.
- Reset mid-WAIT: pull rst_n low for 2 cycles → outputs zero immediately; no rsp_valid; after release, a held req is re-granted starting from ptr=0.

Source files
------------

// File: rtl/act_unit_arbiter.sv
// Round-robin arbiter sharing one activation unit among R requesters,
// with operand latching, start/done sequencing and a hang watchdog.
module act_unit_arbiter #(
  parameter int S       = 32,
  parameter int N       = 2,
  parameter int R       = 4,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     req,
  input  logic [R*S*N-1:0] req_x,
  output logic [R-1:0]     gnt,
  output logic [R-1:0]     rsp_valid,
  output logic [S*N-1:0]   rsp_y,
  output logic             rsp_err,
  output logic             unit_start,
  output logic [S*N-1:0]   unit_x,
  input  logic [S*N-1:0]   unit_y,
  input  logic             unit_done,
  output logic             busy
);

  localparam int SN = S * N;
  localparam int PW = $clog2(R);

  typedef enum logic [2:0] {
    IDLE,
    START,
    GUARD,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   sel_q;
  logic [CW-1:0]   wd_q;
  logic [R-1:0]    gnt_q;
  logic [R-1:0]    rsp_valid_q;
  logic [SN-1:0]   rsp_y_q;
  logic            rsp_err_q;
  logic            unit_start_q;
  logic [SN-1:0]   unit_x_q;
  logic            busy_q;

  logic [SN-1:0]   xv [R];
  logic [PW-1:0]   win_d;
  logic [PW-1:0]   idx;
  logic            found;

  for (genvar r = 0; r < R; r++) begin : g_x
    assign xv[r] = req_x[r*SN +: SN];
  end

  // First requester at or after ptr, wrapping mod R
  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < R; i++) begin
      idx = PW'((int'(ptr_q) + i) % R);
      if (!found && req[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      wd_q         <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_y_q      <= '0;
      rsp_err_q    <= 1'b0;
      unit_start_q <= 1'b0;
      unit_x_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      unit_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            sel_q        <= win_d;
            gnt_q        <= R'(1) << win_d;
            unit_x_q     <= xv[win_d];
            unit_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= START;
          end
        end
        START: state_q <= GUARD;
        // done may still be stale from the previous op here
        GUARD: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (unit_done) begin
            rsp_y_q     <= unit_y;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= gnt_q;
            state_q     <= RESP;
          end else if (wd_q == CW'(TIMEOUT - 1)) begin
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= gnt_q;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          ptr_q   <= (sel_q == PW'(R - 1)) ? '0 : sel_q + 1'b1;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_err    = rsp_err_q;
  assign unit_start = unit_start_q;
  assign unit_x     = unit_x_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_act_unit_arbiter.sv
// Bench for act_unit_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model and a behavioural activation unit.
module tb_act_unit_arbiter;

  localparam int S  = 32;
  localparam int N  = 2;
  localparam int R  = 4;
  localparam int TO = 20;
  localparam int CW = 16;
  localparam int SN = S * N;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [R-1:0]     req;
  logic [R*SN-1:0]  req_x;
  logic [R-1:0]     gnt;
  logic [R-1:0]     rsp_valid;
  logic [SN-1:0]    rsp_y;
  logic             rsp_err;
  logic             unit_start;
  logic [SN-1:0]    unit_x;
  logic [SN-1:0]    unit_y;
  logic             unit_done;
  logic             busy;

  logic [SN-1:0]    xs [R];
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;
  int               ptr_m = 0;
  int               waited [R];

  // activation unit model controls
  bit               hang = 1'b0;
  bit               stale = 1'b0;
  int               lat = 12;
  int               ucnt = 0;
  bit               upend = 1'b0;
  bit               uclr = 1'b0;
  logic [SN-1:0]    ux = '0;
  logic [SN-1:0]    uy = '0;
  logic             udone = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_x = '0;
    for (int r = 0; r < R; r++) req_x[r*SN +: SN] = xs[r];
  end

  act_unit_arbiter #(
    .S(S), .N(N), .R(R), .TIMEOUT(TO), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_x(req_x),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_y(rsp_y),
    .rsp_err(rsp_err),
    .unit_start(unit_start),
    .unit_x(unit_x),
    .unit_y(unit_y),
    .unit_done(unit_done),
    .busy(busy)
  );

  assign unit_y    = uy;
  assign unit_done = udone;

  // hard-sigmoid values for the directed operands, a fixed map otherwise
  function automatic logic [S-1:0] act1(input logic [S-1:0] x);
    case (x)
      32'h3f800000: return 32'h3f400000;
      32'h00000000: return 32'h3f000000;
      32'hbf800000: return 32'h3e800000;
      default:      return x ^ 32'h0000ffff;
    endcase
  endfunction

  function automatic logic [SN-1:0] act_vec(input logic [SN-1:0] x);
    logic [SN-1:0] y;
    y = '0;
    for (int l = 0; l < N; l++) y[l*S +: S] = act1(x[l*S +: S]);
    return y;
  endfunction

  function automatic int pick(input logic [R-1:0] rq, input int p);
    for (int i = 0; i < R; i++)
      if (rq[(p + i) % R]) return (p + i) % R;
    return -1;
  endfunction

  function automatic logic [R-1:0] oh(input int w);
    return R'(1) << w;
  endfunction

  function automatic logic [SN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    if (unit_start) begin
      ux    <= unit_x;
      ucnt  <= lat;
      upend <= 1'b1;
      if (stale) uclr <= 1'b1;
      else udone <= 1'b0;
    end else begin
      if (uclr) begin
        udone <= 1'b0;
        uclr  <= 1'b0;
      end
      if (upend && !hang) begin
        if (ucnt == 0) begin
          udone <= 1'b1;
          uy    <= act_vec(ux);
          upend <= 1'b0;
        end else begin
          ucnt <= ucnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation, entered and left at a negedge in IDLE
  task automatic serve_one(input bit exp_err, input bit drop_mid,
                           input bit keep_req);
    int w, tstart, tdone, trsp;
    logic [SN-1:0] xe;
    w = pick(req, ptr_m);
    for (int k = 0; k < 40; k++) begin
      if (gnt != '0) break;
      @(negedge clk);
    end
    chk("grant_seen", 64'(gnt != '0), 64'(1));
    if (w < 0) w = 0;
    tstart = cyc;
    xe = xs[w];
    chk("gnt_onehot", 64'(gnt), 64'(oh(w)));
    chk("start_hi", 64'(unit_start), 64'(1));
    chk("busy_hi", 64'(busy), 64'(1));
    chk("unit_x", 64'(unit_x), 64'(xe));
    xs[w] = rnd64();
    if (drop_mid) req[w] = 1'b0;
    @(negedge clk);
    chk("start_pulse", 64'(unit_start), 64'(0));
    tdone = -1;
    for (int k = 0; k < TO + 60; k++) begin
      if (rsp_valid != '0) break;
      if (unit_done && tdone < 0 && cyc >= tstart + 2) tdone = cyc;
      @(negedge clk);
    end
    trsp = cyc;
    chk("rsp_valid", 64'(rsp_valid), 64'(oh(w)));
    chk("gnt_resp", 64'(gnt), 64'(oh(w)));
    chk("unit_x_hold", 64'(unit_x), 64'(xe));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_y", 64'(rsp_y), exp_err ? 64'(0) : 64'(act_vec(xe)));
    if (exp_err) chk("to_latency", 64'(trsp - tstart), 64'(TO + 2));
    else chk("done_latency", 64'(trsp), 64'(tdone + 1));
    for (int r = 0; r < R; r++) begin
      if (r == w) waited[r] = 0;
      else if (req[r]) begin
        waited[r]++;
        chk("fairness", 64'(waited[r] <= R - 1), 64'(1));
      end else waited[r] = 0;
    end
    ptr_m = (w + 1) % R;
    if (!keep_req) req[w] = 1'b0;
    @(negedge clk);
    chk("rsp_once", 64'(rsp_valid), 64'(0));
    chk("gnt_clear", 64'(gnt), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int r = 0; r < R; r++) begin
      xs[r] = '0;
      waited[r] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_y", 64'(rsp_y), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_start", 64'(unit_start), 64'(0));
    chk("rst_unit_x", 64'(unit_x), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // single request
    xs[0] = {32'h3f800000, 32'h00000000};
    lat = 12;
    req = 4'b0001;
    serve_one(1'b0, 1'b0, 1'b0);

    // two requesters: r1, r3, then r1 again
    xs[1] = rnd64();
    xs[3] = {32'hbf800000, 32'hbf800000};
    req = 4'b1010;
    serve_one(1'b0, 1'b0, 1'b1);
    serve_one(1'b0, 1'b0, 1'b0);
    serve_one(1'b0, 1'b0, 1'b0);

    // all requesting for eight operations
    for (int r = 0; r < R; r++) xs[r] = rnd64();
    req = 4'b1111;
    lat = 3;
    for (int i = 0; i < 8; i++) serve_one(1'b0, 1'b0, 1'b1);
    req = '0;

    // stale done from the previous op must not be taken in GUARD
    stale = 1'b1;
    lat = 6;
    xs[2] = rnd64();
    req = 4'b0100;
    serve_one(1'b0, 1'b0, 1'b0);
    req = 4'b0100;
    serve_one(1'b0, 1'b0, 1'b0);
    stale = 1'b0;

    // hung unit, then a normal op
    hang = 1'b1;
    lat = 12;
    req = 4'b0001;
    serve_one(1'b1, 1'b0, 1'b0);
    hang = 1'b0;
    req = 4'b0010;
    serve_one(1'b0, 1'b1, 1'b0);

    // reset while waiting on r3 with ptr at 3
    req = 4'b0100;
    serve_one(1'b0, 1'b0, 1'b0);
    req = 4'b1000;
    for (int k = 0; k < 40; k++) begin
      if (gnt != '0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_unit_x", 64'(unit_x), 64'(0));
    chk("mid_rst_rsp_y", 64'(rsp_y), 64'(0));
    chk("mid_rst_err", 64'(rsp_err), 64'(0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
    end
    rst_n = 1'b1;
    ptr_m = 0;
    for (int r = 0; r < R; r++) waited[r] = 0;
    req = 4'b1001;
    serve_one(1'b0, 1'b0, 1'b0);
    serve_one(1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < R; r++) begin
        if (!req[r] && $urandom_range(0, 2) == 0) begin
          req[r] = 1'b1;
          xs[r] = rnd64();
        end
      end
      if (req == '0) req[$urandom_range(0, R - 1)] = 1'b1;
      lat = $urandom_range(2, 15);
      stale = 1'($urandom_range(0, 1));
      serve_one(1'b0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
